// File: rtl/read_buttons_pkg.sv
// read_buttons_pkg: shared definitions for the read_buttons block.
//   state_t        - handshake FSM state encoding (IDLE, DONE)
//   WIDTH_DEF      - default number of buttons / result bits
//   DEBOUNCE_DEF   - default debounce persistence in synchronized cycles
//   cnt_width()    - width of the per-bit debounce counter
package read_buttons_pkg;

   localparam int WIDTH_DEF    = 4;
   localparam int DEBOUNCE_DEF = 16;

   typedef enum logic {
      IDLE = 1'b0,
      DONE = 1'b1
   } state_t;

   // Counter only has to hold 0..DEBOUNCE_CYCLES-1.
   function automatic int cnt_width(input int cycles);
      return $clog2(cycles);
   endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce: one button bit -> 2-flop synchronizer -> accepted level.
// Optional feature macro: READ_BUTTONS_DEBOUNCE_EN
//   defined   : a changed level must persist DEBOUNCE_CYCLES synchronized
//               cycles before the stable output follows it.
//   undefined : stable follows the synchronized level one cycle later.
// Ports:
//   __clk     in   clock, rising edge
//   __resetn  in   asynchronous active-low reset
//   button    in   raw asynchronous button level (1 = pressed)
//   stable    out  accepted (debounced) level
module button_debounce
   import read_buttons_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
   input  logic __clk,
   input  logic __resetn,
   input  logic button,
   output logic stable
);

   logic sync_q1;
   logic sync_q2;
   logic stable_q;

   always_ff @(posedge __clk or negedge __resetn) begin
      if (!__resetn) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= button;
         sync_q2 <= sync_q1;
      end
   end

`ifdef READ_BUTTONS_DEBOUNCE_EN
   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] cnt_q;

   // The counter tracks how long sync has disagreed with stable. Holding
   // at CNT_TC with the level still different is the DEBOUNCE_CYCLES-th
   // differing sample, so the new level is accepted there and the counter
   // restarts; it therefore never wraps.
   always_ff @(posedge __clk or negedge __resetn) begin
      if (!__resetn) begin
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else if (sync_q2 == stable_q) begin
         cnt_q <= '0;
      end else if (cnt_q == CNT_TC) begin
         stable_q <= sync_q2;
         cnt_q    <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end
`else
   always_ff @(posedge __clk or negedge __resetn) begin
      if (!__resetn) begin
         stable_q <= 1'b0;
      end else begin
         stable_q <= sync_q2;
      end
   end
`endif

   assign stable = stable_q;

endmodule

// File: rtl/read_buttons.sv
// read_buttons: returns the accepted button levels on a start/valid call.
// Optional feature macro: READ_BUTTONS_DEBOUNCE_EN (debounce in each bit).
// Ports:
//   __clk     in   clock, rising edge
//   __resetn  in   asynchronous active-low reset
//   buttons   in   WIDTH raw asynchronous buttons, 1 = pressed
//   __start   in   call request, sampled only while __idle = 1
//   __result  out  WIDTH registered return value, held between calls
//   __valid   out  one-cycle pulse, __result valid
//   __idle    out  ready to accept __start
//
// state | meaning
// IDLE  | waiting for __start; __idle = 1
// DONE  | __result just loaded; __valid = 1, __start ignored
module read_buttons
   import read_buttons_pkg::*;
#(
   parameter int WIDTH           = WIDTH_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
   input  logic             __clk,
   input  logic             __resetn,
   input  logic [WIDTH-1:0] buttons,
   input  logic             __start,
   output logic [WIDTH-1:0] __result,
   output logic             __valid,
   output logic             __idle
);

   logic [WIDTH-1:0] stable;
   state_t           state_q;
   state_t           state_d;
   logic             load;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      button_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .__clk   (__clk),
         .__resetn(__resetn),
         .button  (buttons[i]),
         .stable  (stable[i])
      );
   end

   always_ff @(posedge __clk or negedge __resetn) begin
      if (!__resetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         IDLE: begin
            if (__start) begin
               state_d = DONE;
               load    = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Captures stable as it is before this edge, so a coincident stable
   // update is returned on the next call, not this one.
   always_ff @(posedge __clk or negedge __resetn) begin
      if (!__resetn) begin
         __result <= '0;
      end else if (load) begin
         __result <= stable;
      end
   end

   assign __idle  = (state_q == IDLE);
   assign __valid = (state_q == DONE);

endmodule

// File: tb/tb_read_buttons.sv
module tb_read_buttons;

   logic       clk;
   logic       resetn;
   logic [3:0] buttons;
   logic       start;
   logic [3:0] result;
   logic       valid;
   logic       idle;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int valid_cnt = 0;
   logic [3:0] exp_q[$];

`ifdef READ_BUTTONS_DEBOUNCE_EN
   localparam int UPD_EDGE  = 18;
   localparam int START_OFS = 2;
`else
   localparam int UPD_EDGE  = 3;
   localparam int START_OFS = 1;
`endif

   read_buttons #(.WIDTH(4), .DEBOUNCE_CYCLES(16)) dut (
      .__clk   (clk),
      .__resetn(resetn),
      .buttons (buttons),
      .__start (start),
      .__result(result),
      .__valid (valid),
      .__idle  (idle)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Scoreboard monitor: every __valid pulse consumes one expected result.
   initial begin
      logic [3:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (valid === 1'b1) begin
            valid_cnt++;
            total_cnt++;
            if (exp_q.size() == 0) begin
               $display("FAIL sb_unexpected_valid: got result %0h with nothing expected", result);
            end else begin
               e = exp_q.pop_front();
               if (result === e && idle === 1'b0) pass_cnt++;
               else $display("FAIL sb_result: got %0h idle %0b expected %0h idle 0", result, idle, e);
            end
         end
      end
   end

   initial begin
      int v0;
      resetn  = 1'b0;
      buttons = 4'h0;
      start   = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_idle", 32'(idle), 32'd1);
      chk("reset_valid", 32'(valid), 32'd0);
      chk("reset_result", 32'(result), 32'd0);

      // First start accepted in the first cycle with reset high.
      @(negedge clk);
      resetn = 1'b1;
      start  = 1'b1;
      exp_q.push_back(4'h0);
      @(negedge clk);
      start = 1'b0;
      chk("first_start_valid", 32'(valid), 32'd1);
      @(negedge clk);
      chk("first_start_idle", 32'(idle), 32'd1);

      // Basic call with 1010 settled.
      buttons = 4'b1010;
      repeat (40) @(negedge clk);
      start = 1'b1;
      exp_q.push_back(4'b1010);
      @(negedge clk);
      start = 1'b0;
      chk("call_valid", 32'(valid), 32'd1);
      chk("call_idle", 32'(idle), 32'd0);
      chk("call_result", 32'(result), 32'hA);
      @(negedge clk);
      chk("call_valid_drop", 32'(valid), 32'd0);
      chk("call_idle_back", 32'(idle), 32'd1);

      // Result holds between calls while inputs move.
      buttons = 4'b0101;
      repeat (5) @(negedge clk);
      chk("result_hold", 32'(result), 32'hA);

      buttons = 4'h0;
      repeat (40) @(negedge clk);

      // 10-cycle glitch on bit0.
      buttons = 4'h1;
      repeat (10) @(negedge clk);
      buttons = 4'h0;
      repeat (30) @(negedge clk);
      start = 1'b1;
`ifdef READ_BUTTONS_DEBOUNCE_EN
      exp_q.push_back(4'h0);
`else
      exp_q.push_back(4'h0);
`endif
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);

      // bit3 rises before edge 1; start held from edge START_OFS. A call
      // accepted at edge UPD_EDGE coincides with the stable update and
      // must still return the old level.
      for (int k = 1; k <= 32; k++) begin
         if (k == 1) buttons = 4'h8;
         start = (k >= START_OFS);
         if (k >= START_OFS && ((k - START_OFS) % 2) == 0)
            exp_q.push_back((k > UPD_EDGE) ? 4'h8 : 4'h0);
         @(negedge clk);
      end
      start = 1'b0;
      repeat (3) @(negedge clk);

      // Start held 10 cycles -> 5 calls.
      v0    = valid_cnt;
      start = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         if (k % 2 == 1) exp_q.push_back(4'h8);
         @(negedge clk);
         chk("held_valid", 32'(valid), 32'(k % 2));
         chk("held_idle", 32'(idle), 32'((k + 1) % 2));
      end
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("held_pulse_count", 32'(valid_cnt - v0), 32'd5);

`ifndef READ_BUTTONS_DEBOUNCE_EN
      // Undebounced path: 0 -> 5, call accepted on the 4th edge.
      buttons = 4'h0;
      repeat (5) @(negedge clk);
      buttons = 4'h5;
      repeat (3) @(negedge clk);
      start = 1'b1;
      exp_q.push_back(4'h5);
      @(negedge clk);
      start = 1'b0;
      chk("nodeb_result", 32'(result), 32'h5);
      repeat (2) @(negedge clk);
`endif

      // Reset in DONE aborts the call.
      buttons = 4'hF;
      repeat (40) @(negedge clk);
      start = 1'b1;
      exp_q.push_back(4'hF);
      @(negedge clk);
      start = 1'b0;
      chk("pre_abort_valid", 32'(valid), 32'd1);
      #2;
      resetn = 1'b0;
      #1;
      chk("abort_valid", 32'(valid), 32'd0);
      chk("abort_idle", 32'(idle), 32'd1);
      chk("abort_result", 32'(result), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      v0 = valid_cnt;
      repeat (10) @(negedge clk);
      chk("abort_no_valid", 32'(valid_cnt - v0), 32'd0);
      chk("abort_idle_after", 32'(idle), 32'd1);
      chk("abort_result_after", 32'(result), 32'd0);

      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
